// File: rtl/sdram_cmd_arbiter.sv
// Round-robin arbiter feeding the SDRAM controller single-command and burst FIFOs from NUM_REQ requesters.
// Grant in ARB (combinational ready pulse), enq one cycle later in ISSUE; read credits gate single reads.
module sdram_cmd_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int MAX_RD_OUT     = 8,
  parameter int MAX_SINGLE_RUN = 4
) (
  input  logic                          writer_clk,
  input  logic                          writer_rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*41-1:0]         req_cmd_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            bst_valid_i,
  input  logic [NUM_REQ*24-1:0]         bst_addr_i,
  output logic [NUM_REQ-1:0]            bst_ready_o,
  output logic [40:0]                   cmd_d_o,
  output logic                          cmd_enq_o,
  input  logic                          cmd_alm_full_i,
  output logic [31:0]                   bst_d_o,
  output logic                          bst_enq_o,
  input  logic                          bst_alm_full_i,
  input  logic                          rd_done_i,
  output logic [$clog2(NUM_REQ)-1:0]    owner_o,
  output logic                          owner_valid_o,
  output logic [$clog2(MAX_RD_OUT):0]   credits_o,
  output logic                          err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(MAX_RD_OUT);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAX_SINGLE_RUN + 1);

  typedef enum logic {ARB, ISSUE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   s_last_q, s_last_d, b_last_q, b_last_d;
  logic [RW-1:0]   run_q, run_d;
  logic [40:0]     cmd_q, cmd_d;
  logic [31:0]     bst_q, bst_d;
  logic            cmd_enq_q, cmd_enq_d, bst_enq_q, bst_enq_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [IW-1:0]   own_mem_q [MAX_RD_OUT];
  logic            err_q, err_d;

  logic [NUM_REQ-1:0] s_elig, b_elig;
  logic               s_any, b_any, pick_b, push, pop, fifo_full;
  logic [IW-1:0]      s_win, b_win;

  assign fifo_full = (cnt_q == CW'(MAX_RD_OUT));

  // A read is only eligible while a credit and an owner slot are free.
  always_comb begin
    s_elig = '0;
    b_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_elig[i] = req_valid_i[i] && !cmd_alm_full_i && (req_cmd_i[41*i+40] || !fifo_full);
      b_elig[i] = bst_valid_i[i] && !bst_alm_full_i;
    end
  end

  always_comb begin
    int s_idx;
    int b_idx;
    s_idx = 0;
    b_idx = 0;
    s_any = 1'b0;
    b_any = 1'b0;
    s_win = '0;
    b_win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s_idx = (int'(s_last_q) + 1 + k) % NUM_REQ;
      b_idx = (int'(b_last_q) + 1 + k) % NUM_REQ;
      if (!s_any && s_elig[IW'(s_idx)]) begin
        s_any = 1'b1;
        s_win = IW'(s_idx);
      end
      if (!b_any && b_elig[IW'(b_idx)]) begin
        b_any = 1'b1;
        b_win = IW'(b_idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    s_last_d    = s_last_q;
    b_last_d    = b_last_q;
    run_d       = run_q;
    cmd_d       = cmd_q;
    bst_d       = bst_q;
    cmd_enq_d   = 1'b0;
    bst_enq_d   = 1'b0;
    req_ready_o = '0;
    bst_ready_o = '0;
    push        = 1'b0;
    pick_b      = b_any && (!s_any || run_q == RW'(MAX_SINGLE_RUN));
    case (state_q)
      ARB: begin
        if (!writer_rst_i) begin
          if (pick_b) begin
            bst_ready_o[b_win] = 1'b1;
            b_last_d           = b_win;
            bst_d              = {8'h00, bst_addr_i[24*b_win +: 24]};
            bst_enq_d          = 1'b1;
            run_d              = '0;
            state_d            = ISSUE;
          end else if (s_any) begin
            req_ready_o[s_win] = 1'b1;
            s_last_d           = s_win;
            cmd_d              = req_cmd_i[41*s_win +: 41];
            cmd_enq_d          = 1'b1;
            push               = !req_cmd_i[41*s_win+40];
            run_d              = b_any ? run_q + RW'(1) : '0;
            state_d            = ISSUE;
          end else begin
            run_d = '0;
          end
        end
      end
      ISSUE:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // A done with nothing outstanding is dropped so credits can never overshoot.
  always_comb begin
    pop   = rd_done_i && (cnt_q != '0);
    err_d = err_q || (rd_done_i && (cnt_q == '0));
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge writer_clk) begin
    if (writer_rst_i) begin
      state_q   <= ARB;
      s_last_q  <= IW'(NUM_REQ - 1);
      b_last_q  <= IW'(NUM_REQ - 1);
      run_q     <= '0;
      cmd_q     <= '0;
      bst_q     <= '0;
      cmd_enq_q <= 1'b0;
      bst_enq_q <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_last_q  <= s_last_d;
      b_last_q  <= b_last_d;
      run_q     <= run_d;
      cmd_q     <= cmd_d;
      bst_q     <= bst_d;
      cmd_enq_q <= cmd_enq_d;
      bst_enq_q <= bst_enq_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge writer_clk) begin
    if (push) own_mem_q[wr_ptr_q] <= s_win;
  end

  assign cmd_d_o       = cmd_q;
  assign bst_d_o       = bst_q;
  assign cmd_enq_o     = cmd_enq_q && !writer_rst_i;
  assign bst_enq_o     = bst_enq_q && !writer_rst_i;
  assign owner_o       = own_mem_q[rd_ptr_q];
  assign owner_valid_o = (cnt_q != '0);
  assign credits_o     = CW'(MAX_RD_OUT) - cnt_q;
  assign err_o         = err_q;

endmodule
